// File: rtl/sign_frame_analyzer.sv
// Streaming RGB->YCbCr object analyzer: per-pixel classification plus per-frame
// bounding box, pixel count and finger (run) estimate published through a valid/ready port.
module sign_frame_analyzer #(
  parameter int PIX_W = 8,
  parameter int COL_W = 8,
  parameter int ROW_W = 8,
  parameter int CNT_W = 16,
  parameter int RUN_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] in_red,
  input  logic [PIX_W-1:0] in_green,
  input  logic [PIX_W-1:0] in_blue,
  input  logic             in_sof,
  input  logic             in_eol,
  input  logic             in_eof,
  input  logic [1:0]       cfg_mode,
  input  logic [PIX_W-1:0] cfg_cb_min,
  input  logic [PIX_W-1:0] cfg_cb_max,
  input  logic [PIX_W-1:0] cfg_cr_min,
  input  logic [PIX_W-1:0] cfg_cr_max,
  input  logic [PIX_W-1:0] cfg_bg_luma,
  input  logic [PIX_W-1:0] cfg_thresh,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [COL_W-1:0] res_min_col,
  output logic [COL_W-1:0] res_max_col,
  output logic [ROW_W-1:0] res_min_row,
  output logic [ROW_W-1:0] res_max_row,
  output logic [CNT_W-1:0] res_count,
  output logic [RUN_W-1:0] res_fingers,
  output logic             res_empty,
  output logic             res_overrun
);
  localparam int STAGES = 2;
  localparam int PW = PIX_W + 8;
  localparam int SW = PIX_W + 11;
  localparam logic signed [SW-1:0] S_MAX  = SW'((1 << PIX_W) - 1);
  localparam logic signed [SW-1:0] S_HALF = SW'(1 << (PIX_W - 1));

  typedef struct packed {
    logic [1:0]       mode;
    logic [PIX_W-1:0] cb_min, cb_max, cr_min, cr_max, bg, th;
  } cfg_t;
  typedef struct packed { logic sof; logic eol; logic eof; } flg_t;
  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  function automatic logic [PW-1:0] mulk(input logic [PIX_W-1:0] a, input int k);
    return PW'(a) * PW'(k);
  endfunction

  function automatic logic [PIX_W-1:0] clampf(input logic signed [SW-1:0] v);
    if (v < 0) return '0;
    else if (v > S_MAX) return '1;
    else return v[PIX_W-1:0];
  endfunction

  logic [STAGES:0]          r_vld_pipe;
  flg_t [STAGES:0]          r_flg_pipe;
  logic [2:0][2:0][PW-1:0]  r_prod;
  cfg_t                     r_cfg_in, r_cfg_p, w_cfg_in;
  logic [PIX_W-1:0]         r_y, r_cb, r_cr;
  logic signed [SW-1:0]     w_ys, w_cbs, w_crs;
  logic                     r_obj, w_obj, w_skin, w_diff;
  logic [PIX_W-1:0]         w_ad;

  assign w_cfg_in = '{cfg_mode, cfg_cb_min, cfg_cb_max, cfg_cr_min, cfg_cr_max,
                      cfg_bg_luma, cfg_thresh};

  // Stage 1: products; cfg is captured with the sof pixel as it enters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_pipe <= '0;
      r_flg_pipe <= '0;
      r_prod     <= '0;
      r_cfg_in   <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:0], in_valid};
      r_flg_pipe <= {r_flg_pipe[STAGES-1:0], (in_valid ? flg_t'({in_sof, in_eol, in_eof}) : flg_t'('0))};
      r_prod[0][0] <= mulk(in_red, 77);  r_prod[0][1] <= mulk(in_green, 150); r_prod[0][2] <= mulk(in_blue, 29);
      r_prod[1][0] <= mulk(in_red, 43);  r_prod[1][1] <= mulk(in_green, 85);  r_prod[1][2] <= mulk(in_blue, 128);
      r_prod[2][0] <= mulk(in_red, 128); r_prod[2][1] <= mulk(in_green, 107); r_prod[2][2] <= mulk(in_blue, 21);
      if (in_valid && in_sof) r_cfg_in <= w_cfg_in;
    end
  end

  always_comb begin
    w_ys  = $signed(SW'(r_prod[0][0])) + $signed(SW'(r_prod[0][1])) + $signed(SW'(r_prod[0][2]));
    w_cbs = $signed(SW'(r_prod[1][2])) - $signed(SW'(r_prod[1][0])) - $signed(SW'(r_prod[1][1]));
    w_crs = $signed(SW'(r_prod[2][0])) - $signed(SW'(r_prod[2][1])) - $signed(SW'(r_prod[2][2]));
  end

  // Stage 2: YCbCr; cfg follows the sof pixel one stage on so a trailing frame keeps its own cfg
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_y <= '0; r_cb <= '0; r_cr <= '0; r_cfg_p <= '0;
    end else begin
      r_y  <= clampf(w_ys >>> 8);
      r_cb <= clampf((w_cbs >>> 8) + S_HALF);
      r_cr <= clampf((w_crs >>> 8) + S_HALF);
      if (r_vld_pipe[0] && r_flg_pipe[0].sof) r_cfg_p <= r_cfg_in;
    end
  end

  always_comb begin
    w_ad   = (r_y >= r_cfg_p.bg) ? r_y - r_cfg_p.bg : r_cfg_p.bg - r_y;
    w_diff = w_ad > r_cfg_p.th;
    w_skin = (r_cb >= r_cfg_p.cb_min) && (r_cb <= r_cfg_p.cb_max) &&
             (r_cr >= r_cfg_p.cr_min) && (r_cr <= r_cfg_p.cr_max);
    case (r_cfg_p.mode)
      2'd0:    w_obj = w_skin;
      2'd1:    w_obj = w_diff;
      2'd2:    w_obj = w_skin && w_diff;
      default: w_obj = w_skin || w_diff;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_obj <= 1'b0;
    else      r_obj <= w_obj;
  end

  // Accumulator
  state_t           r_state, w_state_nxt;
  logic             w_take, w_abort, w_done, w_px, w_sof, w_eol, w_eof;
  logic [COL_W-1:0] r_col, w_col, r_minc, r_maxc, w_minc_b, w_maxc_b, w_minc_n, w_maxc_n;
  logic [ROW_W-1:0] r_row, w_row, r_minr, r_maxr, w_minr_b, w_maxr_b, w_minr_n, w_maxr_n;
  logic [CNT_W-1:0] r_cnt, w_cnt_b, w_cnt_n;
  logic [RUN_W-1:0] r_runs, r_maxrun, w_runs_b, w_runs_n, w_mrun_b, w_mrun_n;
  logic             r_prev, w_prev, w_start, r_abort, r_pub;

  assign w_px  = r_vld_pipe[STAGES];
  assign w_sof = r_flg_pipe[STAGES].sof;
  assign w_eof = r_flg_pipe[STAGES].eof;
  assign w_eol = r_flg_pipe[STAGES].eol | w_eof;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take = 1'b0; w_abort = 1'b0; w_done = 1'b0;
    case (r_state)
      S_IDLE: if (w_px && w_sof) begin
        w_take = 1'b1; w_done = w_eof;
        w_state_nxt = w_eof ? S_IDLE : S_ACTIVE;
      end
      default: if (w_px) begin
        w_take = 1'b1; w_abort = w_sof; w_done = w_eof;
        if (w_eof) w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_col    = w_sof ? '0 : r_col;
    w_row    = w_sof ? '0 : r_row;
    w_prev   = w_sof ? 1'b0 : r_prev;
    w_cnt_b  = w_sof ? '0 : r_cnt;
    w_runs_b = w_sof ? '0 : r_runs;
    w_mrun_b = w_sof ? '0 : r_maxrun;
    w_minc_b = w_sof ? '1 : r_minc;
    w_maxc_b = w_sof ? '0 : r_maxc;
    w_minr_b = w_sof ? '1 : r_minr;
    w_maxr_b = w_sof ? '0 : r_maxr;
    w_cnt_n  = (r_obj && w_cnt_b != '1) ? w_cnt_b + CNT_W'(1) : w_cnt_b;
    w_minc_n = (r_obj && w_col < w_minc_b) ? w_col : w_minc_b;
    w_maxc_n = (r_obj && w_col > w_maxc_b) ? w_col : w_maxc_b;
    w_minr_n = (r_obj && w_row < w_minr_b) ? w_row : w_minr_b;
    w_maxr_n = (r_obj && w_row > w_maxr_b) ? w_row : w_maxr_b;
    w_start  = r_obj && (w_col == '0 || !w_prev);
    w_runs_n = (w_start && w_runs_b != '1) ? w_runs_b + RUN_W'(1) : w_runs_b;
    w_mrun_n = (w_eol && w_runs_n > w_mrun_b) ? w_runs_n : w_mrun_b;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col <= '0; r_row <= '0; r_cnt <= '0; r_runs <= '0; r_maxrun <= '0; r_prev <= 1'b0;
      r_minc <= '0; r_maxc <= '0; r_minr <= '0; r_maxr <= '0;
      r_abort <= 1'b0; r_pub <= 1'b0;
    end else begin
      r_pub   <= w_done;
      r_abort <= w_abort | (r_abort & ~r_pub);
      if (w_take) begin
        r_cnt <= w_cnt_n; r_maxrun <= w_mrun_n;
        r_minc <= w_minc_n; r_maxc <= w_maxc_n; r_minr <= w_minr_n; r_maxr <= w_maxr_n;
        r_prev <= w_eol ? 1'b0 : r_obj;
        r_runs <= w_eol ? '0 : w_runs_n;
        r_col  <= w_eol ? '0 : ((w_col == '1) ? w_col : w_col + COL_W'(1));
        r_row  <= (w_eol && w_row != '1) ? w_row + ROW_W'(1) : w_row;
      end
    end
  end

  // Result port: a publish always wins over a same-cycle consume
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_valid <= 1'b0; res_min_col <= '0; res_max_col <= '0; res_min_row <= '0;
      res_max_row <= '0; res_count <= '0; res_fingers <= '0; res_empty <= 1'b0; res_overrun <= 1'b0;
    end else if (r_pub) begin
      res_valid   <= 1'b1;
      res_empty   <= (r_cnt == '0);
      res_count   <= r_cnt;
      res_fingers <= r_maxrun;
      res_min_col <= (r_cnt == '0) ? '0 : r_minc;
      res_max_col <= (r_cnt == '0) ? '0 : r_maxc;
      res_min_row <= (r_cnt == '0) ? '0 : r_minr;
      res_max_row <= (r_cnt == '0) ? '0 : r_maxr;
      res_overrun <= r_abort | (res_valid & ~res_ready);
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sign_frame_analyzer.sv
// Directed bench for sign_frame_analyzer: black/white frames with hand-computed results.
module tb_sign_frame_analyzer;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_sof, in_eol, in_eof;
  logic [7:0] in_red, in_green, in_blue;
  logic [1:0] cfg_mode;
  logic [7:0] cfg_cb_min, cfg_cb_max, cfg_cr_min, cfg_cr_max, cfg_bg_luma, cfg_thresh;
  logic       res_valid, res_ready, res_empty, res_overrun;
  logic [7:0] res_min_col, res_max_col, res_min_row, res_max_row;
  logic [15:0] res_count;
  logic [2:0] res_fingers;
  int nchk = 0, npass = 0;

  sign_frame_analyzer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_red(in_red), .in_green(in_green),
    .in_blue(in_blue), .in_sof(in_sof), .in_eol(in_eol), .in_eof(in_eof),
    .cfg_mode(cfg_mode), .cfg_cb_min(cfg_cb_min), .cfg_cb_max(cfg_cb_max),
    .cfg_cr_min(cfg_cr_min), .cfg_cr_max(cfg_cr_max), .cfg_bg_luma(cfg_bg_luma),
    .cfg_thresh(cfg_thresh), .res_valid(res_valid), .res_ready(res_ready),
    .res_min_col(res_min_col), .res_max_col(res_max_col), .res_min_row(res_min_row),
    .res_max_row(res_max_row), .res_count(res_count), .res_fingers(res_fingers),
    .res_empty(res_empty), .res_overrun(res_overrun));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic idle();
    in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0; in_eof = 1'b0;
    in_red = '0; in_green = '0; in_blue = '0;
  endtask

  // White pixel where mask bit (row*w+col) is set, black otherwise; npx truncates the frame
  task automatic frame(input int w, input int h, input logic [255:0] mask, input int npx,
                       input bit gap, input bit mid_en, input logic [1:0] mid_mode);
    int k;
    k = 0;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        if (k < npx) begin
          in_valid = 1'b1;
          {in_red, in_green, in_blue} = mask[r*w+c] ? 24'hFFFFFF : 24'h0;
          in_sof = (r == 0 && c == 0);
          in_eol = (c == w - 1);
          in_eof = (r == h - 1 && c == w - 1);
          step(1);
          k++;
          idle();
          if (mid_en && k == 1) cfg_mode = mid_mode;
          if (gap && c == w - 1 && r != h - 1) step(1);
        end
    idle();
  endtask

  task automatic wait_res(input string tag);
    int n;
    n = 0;
    while (!res_valid && n < 20) begin step(1); n++; end
    chk({tag, "_valid"}, res_valid, 1);
  endtask

  task automatic chk_res(input string t, input int mnc, input int mxc, input int mnr, input int mxr,
                         input int cnt, input int fing, input int emp, input int ovr);
    chk({t, "_min_col"}, res_min_col, mnc);
    chk({t, "_max_col"}, res_max_col, mxc);
    chk({t, "_min_row"}, res_min_row, mnr);
    chk({t, "_max_row"}, res_max_row, mxr);
    chk({t, "_count"}, res_count, cnt);
    chk({t, "_fingers"}, res_fingers, fing);
    chk({t, "_empty"}, res_empty, emp);
    chk({t, "_overrun"}, res_overrun, ovr);
  endtask

  task automatic consume(input string t);
    res_ready = 1'b1; step(1); res_ready = 1'b0;
    chk({t, "_drop"}, res_valid, 0);
  endtask

  initial begin
    logic [255:0] m;
    idle();
    rst = 1'b0; res_ready = 1'b0;
    cfg_mode = 2'd1; cfg_bg_luma = 8'd0; cfg_thresh = 8'd100;
    cfg_cb_min = 8'd77; cfg_cb_max = 8'd127; cfg_cr_min = 8'd133; cfg_cr_max = 8'd173;
    step(3);
    chk("rst_valid", res_valid, 0);
    chk("rst_count", res_count, 0);
    chk("rst_overrun", res_overrun, 0);
    chk("rst_empty", res_empty, 0);
    rst = 1'b1;
    step(2);

    // 4x4, two white pixels on the diagonal, gaps between rows
    m = '0; m[5] = 1'b1; m[10] = 1'b1;
    frame(4, 4, m, 16, 1'b1, 1'b0, 2'd0);
    wait_res("diag");
    chk_res("diag", 1, 2, 1, 2, 2, 1, 0, 0);
    consume("diag");

    // 8-wide alternating row, also checks eof-to-valid latency
    m = '0; for (int i = 0; i < 8; i += 2) m[i] = 1'b1;
    frame(8, 1, m, 8, 1'b0, 1'b0, 2'd0);
    step(3);
    chk("lat_before", res_valid, 0);
    step(1);
    chk("lat_at", res_valid, 1);
    chk_res("alt8", 0, 6, 0, 0, 4, 4, 0, 0);
    consume("alt8");

    // 16-wide alternating: 8 runs saturate at 7
    m = '0; for (int i = 0; i < 16; i += 2) m[i] = 1'b1;
    frame(16, 1, m, 16, 1'b0, 1'b0, 2'd0);
    wait_res("alt16");
    chk_res("alt16", 0, 14, 0, 0, 8, 7, 0, 0);
    consume("alt16");

    // All-black in skin mode: Cb=Cr=128, outside the Cr window
    cfg_mode = 2'd0;
    frame(4, 4, '0, 16, 1'b0, 1'b0, 2'd0);
    wait_res("black");
    chk_res("black", 0, 0, 0, 0, 0, 0, 1, 0);
    consume("black");

    // Back-to-back frames with res_ready low: second overwrites first
    cfg_mode = 2'd1;
    m = '0; m[5] = 1'b1; m[10] = 1'b1;
    frame(4, 4, m, 16, 1'b0, 1'b0, 2'd0);
    m = '0; m[2] = 1'b1;
    frame(2, 2, m, 4, 1'b0, 1'b0, 2'd0);
    step(5);
    chk("ovr_valid", res_valid, 1);
    chk_res("ovr", 0, 0, 1, 1, 1, 1, 0, 1);
    consume("ovr");

    // Abort: partial all-white frame, then a new 2x2 frame
    m = '1;
    frame(4, 4, m, 3, 1'b0, 1'b0, 2'd0);
    step(6);
    chk("abort_nores", res_valid, 0);
    m = '0; m[3] = 1'b1;
    frame(2, 2, m, 4, 1'b0, 1'b0, 2'd0);
    wait_res("abort");
    chk_res("abort", 1, 1, 1, 1, 1, 1, 0, 1);
    consume("abort");

    // Mode 1 -> 0 after first pixel: this frame diff-classified, next frame skin
    m = '0; m[3:0] = 4'hF;
    frame(2, 2, m, 4, 1'b0, 1'b1, 2'd0);
    wait_res("mode1");
    chk_res("mode1", 0, 1, 0, 1, 4, 1, 0, 0);
    consume("mode1");
    frame(2, 2, m, 4, 1'b0, 1'b0, 2'd0);
    wait_res("mode0");
    chk_res("mode0", 0, 0, 0, 0, 0, 0, 1, 0);
    consume("mode0");

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule

// File: doc/sign_frame_analyzer.md
# sign_frame_analyzer

Parametrised streaming successor of the single-pixel sign path: accepts a framed RGB pixel stream and converts each pixel to YCbCr. Each pixel is classified as object/background by one of four selectable modes. At end of frame the block publishes the object's bounding box, pixel count and a finger estimate (maximum object runs crossing any single row) through a valid/ready result port. It sits between the camera front-end and sign identification, replacing the fixed per-pixel skin/background deciders.

## Interface
- PIX_W, 8: bits per colour channel and per Y/Cb/Cr component
- COL_W, 8: column counter width (max image width 2^COL_W)
- ROW_W, 8: row counter width
- CNT_W, 16: object pixel counter width
- RUN_W, 3: finger (run) counter width

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  pixel present this cycle; always accepted, no backpressure
- in_red / in_green / in_blue  in  PIX_W each  pixel colour
- in_sof  in  1  first pixel of frame (row 0, col 0)
- in_eol  in  1  last pixel of a row
- in_eof  in  1  last pixel of frame (also implies eol)
- cfg_mode  in  2  0 skin, 1 background-diff, 2 skin AND diff, 3 skin OR diff
- cfg_cb_min / cfg_cb_max / cfg_cr_min / cfg_cr_max  in  PIX_W each  inclusive skin window
- cfg_bg_luma  in  PIX_W  background luma reference
- cfg_thresh  in  PIX_W  diff threshold
- res_valid  out  1  result held
- res_ready  in  1  consumer accepts result
- res_min_col / res_max_col  out  COL_W  box columns
- res_min_row / res_max_row  out  ROW_W  box rows
- res_count  out  CNT_W  object pixels, saturating
- res_fingers  out  RUN_W  max runs in any row, saturating
- res_empty  out  1  no object pixel in frame
- res_overrun  out  1  previous unconsumed result was overwritten, or a frame was aborted

## Operation
- Stage 1: products registered. Stage 2: Y=(77R+150G+29B)>>8; Cb=128+((−43R−85G+128B)>>>8); Cr=128+((128R−107G−21B)>>>8); signed arithmetic shift, clamp to [0, 2^PIX_W−1], registered. Stage 3: classification registered. sof/eol/eof/valid flags travel with data.
- Skin: cb_min≤Cb≤cb_max and cr_min≤Cr≤cr_max. Diff: |Y−cfg_bg_luma| > cfg_thresh (strict).
- All cfg_* shadowed on the accepted sof pixel; mid-frame changes take effect next frame.
- Accumulator FSM: IDLE → ACTIVE on classified sof; ACTIVE → IDLE after classified eof (result published). Classified pixels in IDLE without sof are dropped.
- sof while ACTIVE: current frame aborted, no result, res_overrun set on next published result, new frame starts with that pixel.
- Column counter clears after eol; row counter increments after eol. Both saturate at max, no wrap.
- Box: min/max updated per object pixel; initial min = all-ones, max = 0. res_empty frame publishes box fields as 0.
- Runs: object pixel starts a run if col 0 or previous pixel in row was background. Row run count saturates at 2^RUN_W−1 and is compared to frame max at eol.
- Publish: result registers load, res_valid=1. If res_valid && !res_ready at publish, overwrite and set res_overrun=1. Otherwise res_overrun reflects abort only.
- res_valid clears on res_valid && res_ready, unless a publish occurs same cycle (publish wins, res_valid stays 1, res_overrun=0).

## Timing
- Reset: all outputs 0, FSM IDLE, pipeline valids 0, shadow cfg 0.
- eof pixel accepted at edge N → res_valid high after edge N+4; result fields stable while res_valid.
- Throughput: one pixel per cycle, gaps (in_valid=0) allowed anywhere.
- Back-to-back frames (sof the cycle after eof) fully supported.
- Reset mid-frame: pipeline and result discarded immediately; no partial result.

## Test plan
- 4×4 frame, mode 1, bg_luma=0, thresh=100, white (255,255,255) pixels at (row1,col1),(row2,col2) → after 4 cycles: box col 1..2, row 1..2, count=2, fingers=1, empty=0.
- 8-wide row pattern O B O B O B O B in mode 1 → fingers=4; 16-wide alternating with RUN_W=3 → fingers=7 (saturated).
- All-black 4×4 frame, mode 0, window Cb 77..127, Cr 133..173 → res_empty=1, box fields 0, count 0.
- Hold res_ready=0 over two frames → second result replaces first, res_overrun=1; assert res_ready → res_valid drops next cycle.
- sof injected mid-frame → aborted frame produces no result; next result has res_overrun=1 and counts only the new frame.
- Change cfg_mode 1→0 mid-frame → current frame classified with mode 1; following frame with mode 0.
